seq_detect_prog: RTL and testbench

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

---
 rtl/seq_detect_prog.sv | 97 +++++++++
 tb/tb_seq_detect_prog.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial pattern detector.
// Shifts accepted bits into a history register, flags a registered Moore
// match one clock after the matching bit, and supports overlapping or
// non-overlapping detection selected per accepted bit.
// Optional feature macro: SEQ_DETECT_MATCH_CNT_EN. When it is defined, a
// saturating match counter drives match_count. When it is undefined,
// match_count is tied to zero and no counter flops are built.
module seq_detect_prog #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1010,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  output logic             detect,
  output logic [CNT_W-1:0] match_count
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              detect_q, detect_d;

  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              match;

  // Next-state logic: cfg_load outranks a data bit; a bit counts only when accepted.
  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], in};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    hist_d     = hist_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    detect_d   = 1'b0;
    match      = 1'b0;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      match    = (fill_inc == FILL_FULL) && (hist_shift == pat_q);
      hist_d   = hist_shift;
      // Non-overlapping mode restarts the fill so a fresh PAT_W bits are needed.
      fill_d   = (match && !overlap) ? '0 : fill_inc;
      detect_d = match;
    end
  end

  // State register with synchronous reset that overrides load and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q   <= '0;
      fill_q   <= '0;
      pat_q    <= PAT_RST;
      detect_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      pat_q    <= pat_d;
      detect_q <= detect_d;
    end
  end

  assign detect = detect_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter; holds at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (match && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register; cfg_load leaves the count untouched.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed testbench for seq_detect_prog. Two instances share stimulus:
// one with default parameters, one with CNT_W=2 to exercise saturation.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic       detect, detect2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .detect(detect), .match_count(match_count)
  );

  seq_detect_prog #(.PAT_W(4), .PAT_RST(4'b1010), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .detect(detect2), .match_count(match_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_det);
    logic [7:0] e1;
    logic [1:0] e2;
`ifdef SEQ_DETECT_MATCH_CNT_EN
    e1 = (exp_cnt > 255) ? 8'd255 : 8'(exp_cnt);
    e2 = (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
`else
    e1 = 8'd0;
    e2 = 2'd0;
`endif
    chk({tag, ".det"}, 32'(detect), 32'(exp_det));
    chk({tag, ".det2"}, 32'(detect2), 32'(exp_det));
    chk({tag, ".cnt"}, 32'(match_count), 32'(e1));
    chk({tag, ".cnt2"}, 32'(match_count2), 32'(e2));
  endtask

  task automatic put_bit(input string tag, input logic b, input logic exp_det);
    rst = 1'b0; cfg_load = 1'b0; in_valid = 1'b1; in = b;
    @(posedge clk); #1;
    if (exp_det) exp_cnt++;
    chk_all(tag, exp_det);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; in = 1'b1;
      @(posedge clk); #1;
      chk_all(tag, 1'b0);
    end
  endtask

  // Reset with load and a valid bit also asserted, to show reset wins.
  task automatic do_reset(input string tag);
    rst = 1'b1; cfg_load = 1'b1; cfg_pattern = 4'b1111; in_valid = 1'b1; in = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 0;
    chk_all(tag, 1'b0);
    rst = 1'b0; cfg_load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [3:0] p, input logic b);
    rst = 1'b0; cfg_load = 1'b1; cfg_pattern = p; in_valid = 1'b1; in = b;
    @(posedge clk); #1;
    chk_all(tag, 1'b0);
    cfg_load = 1'b0;
  endtask

  initial begin
    do_reset("rst0");

    // Overlapping: 1,0,1,0,1,0 -> detect after bits 4 and 6.
    overlap = 1'b1;
    put_bit("ov1", 1'b1, 1'b0);
    put_bit("ov2", 1'b0, 1'b0);
    put_bit("ov3", 1'b1, 1'b0);
    put_bit("ov4", 1'b0, 1'b1);
    put_bit("ov5", 1'b1, 1'b0);
    put_bit("ov6", 1'b0, 1'b1);
    idle("ov_idle", 1);

    // Non-overlapping: 1,0,1,0,1,0,1,0 -> detect after bits 4 and 8.
    do_reset("rst1");
    overlap = 1'b0;
    put_bit("no1", 1'b1, 1'b0);
    put_bit("no2", 1'b0, 1'b0);
    put_bit("no3", 1'b1, 1'b0);
    put_bit("no4", 1'b0, 1'b1);
    put_bit("no5", 1'b1, 1'b0);
    put_bit("no6", 1'b0, 1'b0);
    put_bit("no7", 1'b1, 1'b0);
    put_bit("no8", 1'b0, 1'b1);

    // Overlap changed between bits affects only the next match.
    put_bit("oc1", 1'b1, 1'b0);
    put_bit("oc2", 1'b0, 1'b0);
    put_bit("oc3", 1'b1, 1'b0);
    overlap = 1'b1;
    put_bit("oc4", 1'b0, 1'b1);
    put_bit("oc5", 1'b1, 1'b0);
    put_bit("oc6", 1'b0, 1'b1);

    // Gap of in_valid low holds history; detect low through the gap.
    do_reset("rst2");
    put_bit("gap1", 1'b1, 1'b0);
    put_bit("gap2", 1'b0, 1'b0);
    idle("gap_idle", 3);
    put_bit("gap3", 1'b1, 1'b0);
    put_bit("gap4", 1'b0, 1'b1);

    // Saturation: 1010101010 overlapping gives four matches; CNT_W=2 holds at 3.
    do_reset("rst3");
    overlap = 1'b1;
    for (int i = 0; i < 10; i++)
      put_bit("sat", ~1'(i % 2), (i >= 3) && (i % 2 == 1));

    // Load 1101 after 1,1,0; the bit on the load cycle is dropped.
    do_reset("rst4");
    put_bit("ld_pre1", 1'b1, 1'b0);
    put_bit("ld_pre2", 1'b1, 1'b0);
    put_bit("ld_pre3", 1'b0, 1'b0);
    do_load("ld_a", 4'b1101, 1'b1);
    put_bit("ld_a1", 1'b1, 1'b0);
    put_bit("ld_a2", 1'b1, 1'b0);
    put_bit("ld_a3", 1'b0, 1'b0);
    put_bit("ld_a4", 1'b1, 1'b1);
    // A second load keeps the count; a counted load bit would complete 1101 early.
    do_load("ld_b", 4'b1101, 1'b1);
    put_bit("ld_b1", 1'b1, 1'b0);
    put_bit("ld_b2", 1'b0, 1'b0);
    put_bit("ld_b3", 1'b1, 1'b0);

    // Reset mid-sequence discards partial match and restores pattern 1010.
    do_reset("rst5");
    put_bit("rm1", 1'b1, 1'b0);
    put_bit("rm2", 1'b0, 1'b0);
    put_bit("rm3", 1'b1, 1'b0);
    do_reset("rst6");
    put_bit("rm4", 1'b0, 1'b0);
    put_bit("rm5", 1'b1, 1'b0);
    put_bit("rm6", 1'b0, 1'b0);
    put_bit("rm7", 1'b1, 1'b0);
    put_bit("rm8", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
